// File: rtl/dec_ascii_pkg.sv
// Shared constants and types for the decimal ASCII formatter.
// The SIGN state exists only when SIGNED_EN is defined.
package dec_ascii_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0d;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2d;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_LOCATE,
`ifdef SIGNED_EN
    ST_SIGN,
`endif
    ST_EMIT,
    ST_TERM
  } state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one input bit per cycle, MSB first.
// done pulses for one cycle after the last shift; bcd then holds until the next start.
module bin2bcd_seq
  import dec_ascii_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int MaxDigits = 10
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             start,
  input  logic [DataWidth-1:0]             bin,
  output logic                             done,
  output bcd_digit_t [MaxDigits-1:0]       bcd
);

  localparam int CW = $clog2(DataWidth + 1);

  logic [DataWidth-1:0]     shreg;
  logic [CW-1:0]            cnt;
  bcd_digit_t [MaxDigits-1:0] adj;
  logic [4*MaxDigits-1:0]   adj_flat;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < MaxDigits; i++) begin
      if (bcd[i] >= 4'd5) adj[i] = bcd[i] + 4'd3;
    end
  end

  assign adj_flat = adj;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      shreg <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      bcd   <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shreg <= bin;
        cnt   <= CW'(DataWidth);
        bcd   <= '0;
      end else if (cnt != '0) begin
        // the top bit of the BCD vector can never be set, so dropping it is safe
        bcd   <= {adj_flat[4*MaxDigits-2:0], shreg[DataWidth-1]};
        shreg <= shreg << 1;
        cnt   <= cnt - 1'b1;
        done  <= (cnt == CW'(1));
      end
    end
  end

endmodule

// File: rtl/dec_ascii_formatter.sv
// Converts one binary word into an ASCII decimal line terminated by CR.
// Define SIGNED_EN to treat VALUE_DATA as two's complement and emit a leading '-'.
//
// state   | meaning
// IDLE    | READY=1, waiting for VALUE_VALID
// CONVERT | double-dabble running in bin2bcd_seq
// LOCATE  | find most-significant non-zero digit, launch first byte
// SIGN    | '-' on the bus (SIGNED_EN only)
// EMIT    | digit[cnt] on the bus
// TERM    | CR on the bus
module dec_ascii_formatter
  import dec_ascii_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int MaxDigits = 10
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 VALUE_VALID,
  input  logic [DataWidth-1:0] VALUE_DATA,
  output logic                 READY,
  output logic                 SOURCE_VALID,
  output logic [7:0]           SOURCE_DATA
);

  localparam int IW = (MaxDigits > 1) ? $clog2(MaxDigits) : 1;

  state_t                     state;
  logic [IW-1:0]              cnt;
  logic [IW-1:0]              msd_idx;
  logic                       start;
  logic                       conv_done;
  logic [DataWidth-1:0]       conv_bin;
  bcd_digit_t [MaxDigits-1:0] bcd;

  assign start = READY && VALUE_VALID && !RESET;

`ifdef SIGNED_EN
  logic neg_q;
  logic value_neg;
  assign value_neg = VALUE_DATA[DataWidth-1];
  // magnitude kept in DataWidth unsigned bits so the most-negative value stays exact
  assign conv_bin  = value_neg ? ((~VALUE_DATA) + {{(DataWidth-1){1'b0}}, 1'b1}) : VALUE_DATA;
`else
  assign conv_bin  = VALUE_DATA;
`endif

  bin2bcd_seq #(
    .DataWidth (DataWidth),
    .MaxDigits (MaxDigits)
  ) u_bin2bcd (
    .CLK   (CLK),
    .RESET (RESET),
    .start (start),
    .bin   (conv_bin),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // all-zero leaves the index at 0 so a single "0" is emitted
  always_comb begin
    msd_idx = '0;
    for (int i = 0; i < MaxDigits; i++) begin
      if (bcd[i] != 4'd0) msd_idx = IW'(i);
    end
  end

  function automatic logic [7:0] digit_ascii(input bcd_digit_t d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= ST_IDLE;
      READY        <= 1'b1;
      SOURCE_VALID <= 1'b0;
      SOURCE_DATA  <= 8'h00;
      cnt          <= '0;
`ifdef SIGNED_EN
      neg_q        <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (VALUE_VALID) begin
            READY <= 1'b0;
            state <= ST_CONVERT;
`ifdef SIGNED_EN
            neg_q <= value_neg;
`endif
          end
        end
        ST_CONVERT: begin
          if (conv_done) state <= ST_LOCATE;
        end
        ST_LOCATE: begin
          SOURCE_VALID <= 1'b1;
          cnt          <= msd_idx;
`ifdef SIGNED_EN
          if (neg_q) begin
            SOURCE_DATA <= ASCII_MINUS;
            state       <= ST_SIGN;
          end else begin
            SOURCE_DATA <= digit_ascii(bcd[msd_idx]);
            state       <= ST_EMIT;
          end
`else
          SOURCE_DATA <= digit_ascii(bcd[msd_idx]);
          state       <= ST_EMIT;
`endif
        end
`ifdef SIGNED_EN
        ST_SIGN: begin
          SOURCE_DATA <= digit_ascii(bcd[cnt]);
          state       <= ST_EMIT;
        end
`endif
        ST_EMIT: begin
          if (cnt == '0) begin
            SOURCE_DATA <= ASCII_CR;
            state       <= ST_TERM;
          end else begin
            cnt         <= cnt - 1'b1;
            SOURCE_DATA <= digit_ascii(bcd[cnt - 1'b1]);
          end
        end
        ST_TERM: begin
          SOURCE_VALID <= 1'b0;
          READY        <= 1'b1;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_ascii_formatter.sv
// Directed bench for dec_ascii_formatter; signed vectors run when SIGNED_EN is defined.
module tb_dec_ascii_formatter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        VALUE_VALID;
  logic [31:0] VALUE_DATA;
  logic        READY;
  logic        SOURCE_VALID;
  logic [7:0]  SOURCE_DATA;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dec_ascii_formatter #(
    .DataWidth (32),
    .MaxDigits (10)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .VALUE_VALID  (VALUE_VALID),
    .VALUE_DATA   (VALUE_DATA),
    .READY        (READY),
    .SOURCE_VALID (SOURCE_VALID),
    .SOURCE_DATA  (SOURCE_DATA)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // present v for one edge; returns #1 after the accept edge
  task automatic accept(input string tag, input logic [31:0] v);
    @(negedge CLK);
    check_val({tag, "_ready_idle"}, {31'd0, READY}, 32'd1);
    VALUE_DATA  = v;
    VALUE_VALID = 1'b1;
    tick();
    VALUE_VALID = 1'b0;
    check_val({tag, "_ready_drop"}, {31'd0, READY}, 32'd0);
  endtask

  task automatic wait_first(input string tag, input int start_n);
    int n;
    n = start_n;
    while (!SOURCE_VALID && n < 80) begin
      tick();
      n++;
    end
    check_val({tag, "_latency"}, n, 34);
  endtask

  task automatic collect(input string tag, input string exp);
    int k;
    logic [7:0] e;
    k = 0;
    while (SOURCE_VALID && k < 16) begin
      e = (k < exp.len()) ? exp[k] : 8'h0d;
      check_val($sformatf("%s_b%0d", tag, k), {24'd0, SOURCE_DATA}, {24'd0, e});
      k++;
      tick();
    end
    check_val({tag, "_len"}, k, exp.len() + 1);
    check_val({tag, "_ready_end"}, {31'd0, READY}, 32'd1);
  endtask

  task automatic quiet(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      tick();
      if (SOURCE_VALID) seen++;
    end
    check_val(tag, seen, 0);
  endtask

  task automatic line(input string tag, input logic [31:0] v, input string exp);
    accept(tag, v);
    wait_first(tag, 0);
    collect(tag, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET       = 1'b1;
    VALUE_VALID = 1'b0;
    VALUE_DATA  = 32'd0;
    repeat (3) tick();
    check_val("rst_ready", {31'd0, READY}, 32'd1);
    check_val("rst_valid", {31'd0, SOURCE_VALID}, 32'd0);
    check_val("rst_data", {24'd0, SOURCE_DATA}, 32'h00);
    RESET = 1'b0;
    tick();

    line("zero", 32'd0, "0");
    line("v1234", 32'd1234, "1234");
    line("vmax", 32'hFFFF_FFFF, "4294967295");
    check_val("hold_data", {24'd0, SOURCE_DATA}, 32'h0d);

    // a word offered while busy must be dropped
    accept("drop", 32'd7);
    VALUE_DATA  = 32'd99;
    VALUE_VALID = 1'b1;
    repeat (20) tick();
    VALUE_VALID = 1'b0;
    wait_first("drop", 20);
    collect("drop", "7");
    quiet("drop_no_99", 40);

    // reset in the middle of a line aborts without CR
    accept("abort", 32'd12345);
    wait_first("abort", 0);
    check_val("abort_b0", {24'd0, SOURCE_DATA}, 32'h31);
    tick();
    check_val("abort_b1", {24'd0, SOURCE_DATA}, 32'h32);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check_val("abort_valid", {31'd0, SOURCE_VALID}, 32'd0);
    check_val("abort_ready", {31'd0, READY}, 32'd1);
    quiet("abort_no_cr", 40);
    line("after_abort", 32'd5, "5");

    // reset wins over a simultaneous VALUE_VALID
    @(negedge CLK);
    RESET       = 1'b1;
    VALUE_VALID = 1'b1;
    VALUE_DATA  = 32'd9;
    tick();
    RESET       = 1'b0;
    VALUE_VALID = 1'b0;
    check_val("rst_win_ready", {31'd0, READY}, 32'd1);
    quiet("rst_win_no_line", 40);

`ifdef SIGNED_EN
    line("neg5", 32'hFFFF_FFFB, "-5");
    line("most_neg", 32'h8000_0000, "-2147483648");
    line("pos42", 32'd42, "42");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
